// File: rtl/mesh_terminal_endpoint.sv
// mesh_terminal_endpoint: device-side endpoint for one terminal of the bus mesh.
// TX path buffers local packets and offers the FIFO head to the mesh
// (pndng_i_in/data_out_i_in, consumed by popin). RX path drains packets the
// mesh presents by pulsing pop, one packet in flight, into a local FIFO.
// Optional feature macro: MESH_EP_ADDR_CHECK_EN -- drop captured packets whose
// destination row/col differs from MY_ROW/MY_COL and count them in misroute_cnt.
module mesh_terminal_endpoint #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int MY_ROW     = 0,
    parameter int MY_COL     = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               tx_drop,
    output logic               pndng_i_in,
    output logic [pckg_sz-1:0] data_out_i_in,
    input  logic               popin,
    input  logic               pndng,
    input  logic [pckg_sz-1:0] data_out,
    output logic               pop,
    input  logic               rx_pop,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_pndng,
    output logic [CNT_W-1:0]   rx_pkt_cnt
`ifdef MESH_EP_ADDR_CHECK_EN
    ,output logic [CNT_W-1:0]  misroute_cnt
`endif
);

    localparam int PTR_W  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_FW = $clog2(fifo_depth + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(fifo_depth - 1);
    localparam logic [CNT_FW-1:0] DEPTH_C  = CNT_FW'(fifo_depth);
    localparam logic [3:0] MY_ROW_ID = MY_ROW[3:0];
    localparam logic [3:0] MY_COL_ID = MY_COL[3:0];
`ifdef MESH_EP_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_POP, RX_WAIT} rx_state_t;

    // Pointer advance wrapping modulo fifo_depth (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Saturating packet-counter increment
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // ---------------- TX FIFO ----------------
    logic [pckg_sz-1:0] tx_mem [fifo_depth];
    logic [PTR_W-1:0]   tx_wr, tx_rd;
    logic [CNT_FW-1:0]  tx_count;
    logic               tx_wr_en, tx_rd_en;

    assign tx_full       = (tx_count == DEPTH_C);
    assign tx_wr_en      = tx_push && !tx_full;
    assign tx_rd_en      = popin && pndng_i_in;
    assign pndng_i_in    = (tx_count != '0);
    assign data_out_i_in = pndng_i_in ? tx_mem[tx_rd] : '0;

    // TX pointers, occupancy and the drop pulse (full judged on the current count)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            tx_drop  <= 1'b0;
        end else begin
            tx_drop <= tx_push && tx_full;
            if (tx_wr_en) tx_wr <= next_ptr(tx_wr);
            if (tx_rd_en) tx_rd <= next_ptr(tx_rd);
            case ({tx_wr_en, tx_rd_en})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // TX storage; contents are only visible through the count-gated head
    always_ff @(posedge clk) begin
        if (tx_wr_en) tx_mem[tx_wr] <= tx_data;
    end

    // ---------------- RX path ----------------
    rx_state_t          rx_state, rx_state_next;
    logic [pckg_sz-1:0] rx_mem [fifo_depth];
    logic [PTR_W-1:0]   rx_wr, rx_rd;
    logic [CNT_FW-1:0]  rx_count;
    logic               capture, addr_match, rx_wr_en, rx_rd_en;

    // Capture happens at the edge closing the pop cycle; the mesh holds data_out meanwhile
    assign capture    = (rx_state == RX_POP);
    assign addr_match = (data_out[pckg_sz-9 -: 4] == MY_ROW_ID) &&
                        (data_out[pckg_sz-13 -: 4] == MY_COL_ID);
    assign rx_wr_en   = capture && (addr_match || !ADDR_CHECK);
    assign rx_rd_en   = rx_pop && rx_pndng;
    assign rx_pndng   = (rx_count != '0);
    assign rx_data    = rx_pndng ? rx_mem[rx_rd] : '0;

    // RX FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_next;
    end

    // RX FSM next state and pop; the WAIT state gives the mesh a cycle to refresh pndng
    always_comb begin
        rx_state_next = rx_state;
        pop           = 1'b0;
        case (rx_state)
            RX_IDLE: if (pndng && (rx_count < DEPTH_C)) rx_state_next = RX_POP;
            RX_POP: begin
                pop           = 1'b1;
                rx_state_next = RX_WAIT;
            end
            RX_WAIT: rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // RX pointers, occupancy and saturating statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr      <= '0;
            rx_rd      <= '0;
            rx_count   <= '0;
            rx_pkt_cnt <= '0;
        end else begin
            if (rx_wr_en) begin
                rx_wr      <= next_ptr(rx_wr);
                rx_pkt_cnt <= sat_inc(rx_pkt_cnt);
            end
            if (rx_rd_en) rx_rd <= next_ptr(rx_rd);
            case ({rx_wr_en, rx_rd_en})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

`ifdef MESH_EP_ADDR_CHECK_EN
    // Count packets drained from the mesh but addressed to another terminal
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     misroute_cnt <= '0;
        else if (capture && !addr_match) misroute_cnt <= sat_inc(misroute_cnt);
    end
`endif

    // RX storage
    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem[rx_wr] <= data_out;
    end

endmodule

// File: tb/tb_mesh_terminal_endpoint.sv
// Scoreboard bench for mesh_terminal_endpoint: stimulus pushes expected packets
// into queues, monitors pop and compare them when the DUT hands packets out.
module tb_mesh_terminal_endpoint;
    localparam int PS = 40;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_push, popin, pndng, rx_pop;
    logic [PS-1:0] tx_data, data_out;
    logic          tx_full, tx_drop, pndng_i_in, pop, rx_pndng;
    logic [PS-1:0] data_out_i_in, rx_data;
    logic [CW-1:0] rx_pkt_cnt;
`ifdef MESH_EP_ADDR_CHECK_EN
    logic [CW-1:0] misroute_cnt;
`endif

    mesh_terminal_endpoint #(.pckg_sz(PS), .fifo_depth(4), .MY_ROW(0), .MY_COL(1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_drop(tx_drop),
        .pndng_i_in(pndng_i_in), .data_out_i_in(data_out_i_in), .popin(popin),
        .pndng(pndng), .data_out(data_out), .pop(pop),
        .rx_pop(rx_pop), .rx_data(rx_data), .rx_pndng(rx_pndng), .rx_pkt_cnt(rx_pkt_cnt)
`ifdef MESH_EP_ADDR_CHECK_EN
        , .misroute_cnt(misroute_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [PS-1:0] tx_exp[$];
    logic [PS-1:0] rx_exp[$];
    logic [PS-1:0] mesh_q[$];
    int pop_cycles[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [PS-1:0] mk(input logic [7:0] nj, input logic [3:0] r,
                                         input logic [3:0] c, input logic [22:0] pl);
        return {nj, r, c, 1'b0, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [PS-1:0] p);
        tx_push = 1'b1;
        tx_data = p;
        tick();
        tx_push = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Mesh model: offers mesh_q head, retires it after the edge that closes a pop cycle
    initial begin
        logic pend;
        pndng = 1'b0;
        data_out = '0;
        forever begin
            @(negedge clk);
            pend = pop && !reset;
            @(posedge clk);
            #1;
            if (pend && mesh_q.size() > 0) void'(mesh_q.pop_front());
            pndng = (mesh_q.size() > 0);
            data_out = pndng ? mesh_q[0] : '0;
        end
    end

    // Monitor: compares handed-out packets against the scoreboard queues
    initial begin
        logic prev_pop;
        prev_pop = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (popin && pndng_i_in) begin
                    if (tx_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_unexpected actual=%0h expected=none", data_out_i_in);
                    end else chk("tx_order", data_out_i_in, tx_exp.pop_front());
                end
                if (rx_pop && rx_pndng) begin
                    if (rx_exp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
                    end else chk("rx_order", rx_data, rx_exp.pop_front());
                end
                if (pop) begin
                    chk("pop_back_to_back", prev_pop, 1'b0);
                    pop_cycles.push_back(cyc);
                end
            end
            prev_pop = pop;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [PS-1:0] bp [6];
        reset = 1'b1; tx_push = 0; popin = 0; rx_pop = 0; tx_data = '0;
        tick();
        // reset state
        chk("rst_pndng_i_in", pndng_i_in, 0);
        chk("rst_data_out_i_in", data_out_i_in, 0);
        chk("rst_pop", pop, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_drop", tx_drop, 0);
        chk("rst_rx_pndng", rx_pndng, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_pkt_cnt", rx_pkt_cnt, 0);
        @(negedge clk); reset = 1'b0;
        tick();

        // TX fill, overflow drops, drain in order
        for (int i = 0; i < 4; i++) begin
            tx_exp.push_back(mk(8'h10 + 8'(i), 4'h2, 4'h3, 23'h1000 + 23'(i)));
            push_tx(mk(8'h10 + 8'(i), 4'h2, 4'h3, 23'h1000 + 23'(i)));
            if (i == 0) begin
                chk("tx_latency_pndng", pndng_i_in, 1);
                chk("tx_latency_head", data_out_i_in, mk(8'h10, 4'h2, 4'h3, 23'h1000));
            end
        end
        chk("tx_full_at4", tx_full, 1);
        chk("tx_drop_idle", tx_drop, 0);
        push_tx(mk(8'hEE, 4'h0, 4'h0, 23'h7FFFF));
        chk("tx_drop_pulse", tx_drop, 1);
        tx_push = 1'b1; popin = 1'b1; tx_data = mk(8'hEF, 4'h0, 4'h0, 23'h5);
        tick();
        tx_push = 1'b0;
        chk("tx_drop_with_popin", tx_drop, 1);
        chk("tx_full_after_pop", tx_full, 0);
        tick();
        chk("tx_drop_clears", tx_drop, 0);
        repeat (2) tick();
        popin = 1'b0;
        chk("tx_empty_pndng", pndng_i_in, 0);
        chk("tx_empty_head", data_out_i_in, 0);
        chk("tx_scoreboard_drained", tx_exp.size(), 0);

        // simultaneous push and popin keeps the count
        for (int i = 0; i < 5; i++) tx_exp.push_back(mk(8'h20, 4'h1, 4'h1, 23'h200 + 23'(i)));
        push_tx(mk(8'h20, 4'h1, 4'h1, 23'h200));
        push_tx(mk(8'h20, 4'h1, 4'h1, 23'h201));
        popin = 1'b1;
        push_tx(mk(8'h20, 4'h1, 4'h1, 23'h202));
        popin = 1'b0;
        push_tx(mk(8'h20, 4'h1, 4'h1, 23'h203));
        chk("tx_sim_not_full_at3", tx_full, 0);
        push_tx(mk(8'h20, 4'h1, 4'h1, 23'h204));
        chk("tx_sim_full_at4", tx_full, 1);
        popin = 1'b1;
        repeat (4) tick();
        popin = 1'b0;
        chk("tx_sim_empty", pndng_i_in, 0);
        chk("tx_sim_drained", tx_exp.size(), 0);

        // RX: three packets with pndng held -> pops 3 cycles apart
        pop_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            mesh_q.push_back(mk(8'h30, 4'h0, 4'h1, 23'h300 + 23'(i)));
            rx_exp.push_back(mk(8'h30, 4'h0, 4'h1, 23'h300 + 23'(i)));
        end
        for (int k = 0; k < 40 && mesh_q.size() > 0; k++) tick();
        repeat (3) tick();
        chk("rx_pop_count", pop_cycles.size(), 3);
        if (pop_cycles.size() == 3) begin
            chk("rx_pop_gap1", pop_cycles[1] - pop_cycles[0], 3);
            chk("rx_pop_gap2", pop_cycles[2] - pop_cycles[1], 3);
        end
        chk("rx_pkt_cnt_3", rx_pkt_cnt, 3);
        rx_pop = 1'b1;
        repeat (4) tick();          // fourth pop hits an empty FIFO
        rx_pop = 1'b0;
        chk("rx_empty", rx_pndng, 0);
        chk("rx_empty_data", rx_data, 0);

        // RX backpressure with a full FIFO, then rx_pop during a capture
        for (int i = 0; i < 6; i++) begin
            bp[i] = mk(8'h40, 4'h0, 4'h1, 23'h400 + 23'(i));
            mesh_q.push_back(bp[i]);
            rx_exp.push_back(bp[i]);
        end
        for (int k = 0; k < 60 && mesh_q.size() > 2; k++) tick();
        repeat (4) tick();
        pop_cycles.delete();
        repeat (6) tick();
        chk("bp_no_pop", pop_cycles.size(), 0);
        chk("bp_cnt_7", rx_pkt_cnt, 7);
        chk("bp_rx_pndng", rx_pndng, 1);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        lat = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (pop) begin lat = k; break; end
        end
        chk("bp_pop_latency", lat, 1);
        rx_pop = 1'b1;              // local read in the capture cycle
        tick();
        rx_pop = 1'b0;
        repeat (8) tick();
        chk("bp_cnt_9", rx_pkt_cnt, 9);
        chk("bp_mesh_drained", mesh_q.size(), 0);
        rx_pop = 1'b1;
        repeat (4) tick();
        rx_pop = 1'b0;
        chk("bp_rx_empty_after4", rx_pndng, 0);
        chk("bp_scoreboard_drained", rx_exp.size(), 0);

        // packet addressed to another terminal
        mesh_q.push_back(mk(8'h50, 4'h2, 4'h3, 23'h500));
`ifndef MESH_EP_ADDR_CHECK_EN
        rx_exp.push_back(mk(8'h50, 4'h2, 4'h3, 23'h500));
`endif
        for (int k = 0; k < 20 && mesh_q.size() > 0; k++) tick();
        repeat (3) tick();
        chk("mr_drained_from_mesh", mesh_q.size(), 0);
`ifdef MESH_EP_ADDR_CHECK_EN
        chk("mr_misroute_cnt", misroute_cnt, 1);
        chk("mr_rx_pndng", rx_pndng, 0);
        chk("mr_rx_pkt_cnt", rx_pkt_cnt, 9);
`else
        chk("mr_rx_pkt_cnt", rx_pkt_cnt, 10);
        chk("mr_rx_pndng", rx_pndng, 1);
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        chk("mr_rx_empty", rx_pndng, 0);
`endif

        // reset asserted in the middle of a pop cycle
        push_tx(mk(8'h60, 4'h0, 4'h0, 23'h600));
        mesh_q.push_back(mk(8'h61, 4'h0, 4'h1, 23'h601));
        mesh_q.push_back(mk(8'h62, 4'h0, 4'h1, 23'h602));
        for (int k = 0; k < 20 && mesh_q.size() > 1; k++) tick();
        for (int k = 0; k < 10 && !pop; k++) tick();
        chk("rr_pop_before", pop, 1);
        chk("rr_rx_pndng_before", rx_pndng, 1);
        #1 reset = 1'b1;
        #1;
        chk("rr_pop", pop, 0);
        chk("rr_rx_pndng", rx_pndng, 0);
        chk("rr_pndng_i_in", pndng_i_in, 0);
        mesh_q.delete();
        @(negedge clk); reset = 1'b0;
        tick();
        chk("rr_rx_pkt_cnt", rx_pkt_cnt, 0);
        chk("rr_rx_data", rx_data, 0);
        chk("rr_data_out_i_in", data_out_i_in, 0);
`ifdef MESH_EP_ADDR_CHECK_EN
        chk("rr_misroute_cnt", misroute_cnt, 0);
`endif
        repeat (4) tick();
        chk("rr_pop_idle", pop, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
